// File: rtl/enemy_pkg.sv
// ---------------------------------------------------------------------------
// enemy_pkg : shared types, width defaults and helpers for enemy_health_bank
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package enemy_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } enemy_hp_state_t;

  localparam int DEF_HP_W  = 3;
  localparam int DEF_DMG_W = 2;

  // A single-frame window still needs a 1-bit counter to hold its zero value.
  function automatic int cnt_width(input int frames);
    return (frames > 1) ? $clog2(frames) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_health_slot.sv
// ---------------------------------------------------------------------------
// enemy_health_slot : per-enemy health register, invulnerability counter, FSM
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module enemy_health_slot
  import enemy_pkg::*;
#(
  parameter int HP_W          = DEF_HP_W,
  parameter int DMG_W         = DEF_DMG_W,
  parameter int INIT_HP       = 5,
  parameter int INVULN_FRAMES = 120
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             hit_i,
  input  logic             shield_i,
  input  logic [DMG_W-1:0] dmg_i,
  input  logic             respawn_i,
  output logic [HP_W-1:0]  health_o,
  output logic             dead_o,
  output logic             invuln_o,
  output logic             death_pulse_o
);

  localparam int               CNT_W    = cnt_width(INVULN_FRAMES);
  localparam int               SUB_W    = (HP_W > DMG_W) ? HP_W : DMG_W;
  localparam logic [HP_W-1:0]  INIT_VAL = HP_W'(INIT_HP);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_FRAMES - 1);

  enemy_hp_state_t  state_q;
  logic [HP_W-1:0]  hp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;

  logic [SUB_W-1:0] hp_ext;
  logic [SUB_W-1:0] dmg_ext;
  logic [HP_W-1:0]  hp_sub;
  logic             accept;

  // Saturating subtract in the wider of the two widths so no operand truncates.
  assign hp_ext  = SUB_W'(hp_q);
  assign dmg_ext = SUB_W'(dmg_i);
  assign hp_sub  = (dmg_ext >= hp_ext) ? '0 : HP_W'(hp_ext - dmg_ext);
  assign accept  = hit_i & ~shield_i & (dmg_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ALIVE;
      hp_q    <= INIT_VAL;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (tick_i) begin
        case (state_q)
          ALIVE: begin
            if (accept) begin
              hp_q <= hp_sub;
              if (hp_sub == '0) begin
                state_q <= DEAD;
                pulse_q <= 1'b1;
              end else begin
                state_q <= INVULN;
                cnt_q   <= CNT_LOAD;
              end
            end
          end
          INVULN: begin
            if (cnt_q == '0) state_q <= ALIVE;
            else             cnt_q   <= cnt_q - 1'b1;
          end
          DEAD: begin
            hp_q <= '0;
            if (respawn_i) begin
              state_q <= ALIVE;
              hp_q    <= INIT_VAL;
              cnt_q   <= '0;
            end
          end
          default: state_q <= ALIVE;
        endcase
      end
    end
  end

  assign health_o      = hp_q;
  assign dead_o        = (state_q == DEAD);
  assign invuln_o      = (state_q == INVULN);
  assign death_pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/enemy_health_bank.sv
// ---------------------------------------------------------------------------
// enemy_health_bank : frame-tick edge detect and one health slot per enemy
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module enemy_health_bank
  import enemy_pkg::*;
#(
  parameter int NUM_ENEMIES   = 4,
  parameter int HP_W          = DEF_HP_W,
  parameter int DMG_W         = DEF_DMG_W,
  parameter int NORMAL_HP     = 5,
  parameter int BOSS_HP       = 7,
  parameter int BOSS_IDX      = 3,
  parameter int INVULN_FRAMES = 120
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              frame_clk,
  input  logic [NUM_ENEMIES-1:0]            enemy_hit_en,
  input  logic [NUM_ENEMIES-1:0]            is_enemy_shield,
  input  logic [NUM_ENEMIES-1:0][DMG_W-1:0] hit_dmg,
  input  logic [NUM_ENEMIES-1:0]            respawn_en,
  output logic [NUM_ENEMIES-1:0][HP_W-1:0]  health,
  output logic [NUM_ENEMIES-1:0]            dead,
  output logic [NUM_ENEMIES-1:0]            invuln,
  output logic [NUM_ENEMIES-1:0]            death_pulse,
  output logic                              all_dead
);

  logic frame_prev_q;
  logic frame_tick_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_prev_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_prev_q <= frame_clk;
      frame_tick_q <= frame_clk & ~frame_prev_q;
    end
  end

  for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_slot
    enemy_health_slot #(
      .HP_W          (HP_W),
      .DMG_W         (DMG_W),
      .INIT_HP       ((i == BOSS_IDX) ? BOSS_HP : NORMAL_HP),
      .INVULN_FRAMES (INVULN_FRAMES)
    ) u_slot (
      .clk_i         (Clk),
      .rst_i         (Reset),
      .tick_i        (frame_tick_q),
      .hit_i         (enemy_hit_en[i]),
      .shield_i      (is_enemy_shield[i]),
      .dmg_i         (hit_dmg[i]),
      .respawn_i     (respawn_en[i]),
      .health_o      (health[i]),
      .dead_o        (dead[i]),
      .invuln_o      (invuln[i]),
      .death_pulse_o (death_pulse[i])
    );
  end

  assign all_dead = &dead;

endmodule

`default_nettype wire

// File: tb/tb_enemy_health_bank.sv
// ---------------------------------------------------------------------------
// tb_enemy_health_bank : directed + randomized bench for enemy_health_bank
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_enemy_health_bank;

  localparam int N         = 4;
  localparam int HP_W      = 3;
  localparam int DMG_W     = 2;
  localparam int NORMAL_HP = 5;
  localparam int BOSS_HP   = 7;
  localparam int BOSS_IDX  = 3;
  localparam int INV       = 120;

  typedef logic [N-1:0][HP_W-1:0] hvec_t;

  logic                      Clk = 1'b0;
  logic                      Reset;
  logic                      frame_clk;
  logic [N-1:0]              hit;
  logic [N-1:0]              shield;
  logic [N-1:0][DMG_W-1:0]   dmg;
  logic [N-1:0]              respawn;
  hvec_t                     health;
  logic [N-1:0]              dead;
  logic [N-1:0]              invuln;
  logic [N-1:0]              death_pulse;
  logic                      all_dead;

  enemy_health_bank #(
    .NUM_ENEMIES(N), .HP_W(HP_W), .DMG_W(DMG_W), .NORMAL_HP(NORMAL_HP),
    .BOSS_HP(BOSS_HP), .BOSS_IDX(BOSS_IDX), .INVULN_FRAMES(INV)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .enemy_hit_en(hit), .is_enemy_shield(shield), .hit_dmg(dmg),
    .respawn_en(respawn), .health(health), .dead(dead), .invuln(invuln),
    .death_pulse(death_pulse), .all_dead(all_dead)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: health, dead flag, frames of invulnerability left.
  int           m_hp   [N];
  bit           m_dead [N];
  int           m_left [N];
  logic [N-1:0] m_pulse;
  logic [N-1:0] obs_dp1;
  logic [N-1:0] obs_dp2;

  function automatic int init_hp(input int i);
    return (i == BOSS_IDX) ? BOSS_HP : NORMAL_HP;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hp[i] = init_hp(i); m_dead[i] = 1'b0; m_left[i] = 0;
    end
    m_pulse = '0;
  endtask

  task automatic model_tick();
    m_pulse = '0;
    for (int i = 0; i < N; i++) begin
      if (m_dead[i]) begin
        if (respawn[i]) begin
          m_hp[i] = init_hp(i); m_dead[i] = 1'b0; m_left[i] = 0;
        end
      end else if (m_left[i] > 0) begin
        m_left[i]--;
      end else if (hit[i] && !shield[i] && dmg[i] != 0) begin
        m_hp[i] = m_hp[i] - int'(dmg[i]);
        if (m_hp[i] <= 0) begin
          m_hp[i] = 0; m_dead[i] = 1'b1; m_pulse[i] = 1'b1;
        end else begin
          m_left[i] = INV;
        end
      end
    end
  endtask

  function automatic hvec_t exp_health();
    hvec_t v;
    for (int i = 0; i < N; i++) v[i] = HP_W'(m_hp[i]);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_dead();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_dead[i];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_inv();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_left[i] > 0);
    return v;
  endfunction

  task automatic clear_inputs();
    hit = '0; shield = '0; dmg = '0; respawn = '0;
  endtask

  // One frame: raise frame_clk, sample after the state update and one Clk later.
  task automatic do_tick();
    @(negedge Clk) frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1 obs_dp1 = death_pulse;
    model_tick();
    @(negedge Clk) frame_clk = 1'b0;
    @(posedge Clk);
    #1 obs_dp2 = death_pulse;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    frame_clk = 1'b0;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;
    model_reset();
    checks++; if (health !== hvec_t'({3'd7, 3'd5, 3'd5, 3'd5})) begin failures++; $display("FAIL reset_health got=%h want=%h", health, {3'd7, 3'd5, 3'd5, 3'd5}); end
    checks++; if (dead !== 4'b0) begin failures++; $display("FAIL reset_dead got=%b want=0000", dead); end
    checks++; if (invuln !== 4'b0) begin failures++; $display("FAIL reset_invuln got=%b want=0000", invuln); end
    checks++; if (death_pulse !== 4'b0) begin failures++; $display("FAIL reset_pulse got=%b want=0000", death_pulse); end
    checks++; if (all_dead !== 1'b0) begin failures++; $display("FAIL reset_all_dead got=%b want=0", all_dead); end
  endtask

  task automatic test_invuln_window();
    clear_inputs();
    hit[0] = 1'b1; dmg[0] = 2'd2;
    do_tick();
    checks++; if (health[0] !== 3'd3) begin failures++; $display("FAIL hit_health0 got=%0d want=3", health[0]); end
    checks++; if (invuln[0] !== 1'b1) begin failures++; $display("FAIL hit_invuln0 got=%b want=1", invuln[0]); end
    dmg[0] = 2'd3;
    for (int t = 0; t < INV - 1; t++) begin
      do_tick();
      checks++; if (health !== exp_health() || invuln !== exp_inv()) begin
        failures++; $display("FAIL invuln_hold t=%0d health=%h want=%h invuln=%b want=%b", t, health, exp_health(), invuln, exp_inv());
      end
    end
    clear_inputs();
    do_tick();
    checks++; if (invuln[0] !== 1'b0 || health[0] !== 3'd3) begin failures++; $display("FAIL invuln_end invuln0=%b want=0 health0=%0d want=3", invuln[0], health[0]); end
  endtask

  task automatic test_saturate_death();
    clear_inputs();
    hit[1] = 1'b1; dmg[1] = 2'd3; do_tick(); clear_inputs();
    repeat (INV) do_tick();
    hit[1] = 1'b1; dmg[1] = 2'd1; do_tick(); clear_inputs();
    repeat (INV) do_tick();
    checks++; if (health[1] !== 3'd1 || invuln[1] !== 1'b0) begin failures++; $display("FAIL pre_kill health1=%0d want=1 invuln1=%b want=0", health[1], invuln[1]); end
    hit[1] = 1'b1; dmg[1] = 2'd3; do_tick(); clear_inputs();
    checks++; if (health[1] !== 3'd0) begin failures++; $display("FAIL sat_health1 got=%0d want=0", health[1]); end
    checks++; if (dead[1] !== 1'b1) begin failures++; $display("FAIL sat_dead1 got=%b want=1", dead[1]); end
    checks++; if (obs_dp1 !== m_pulse || m_pulse !== 4'b0010) begin failures++; $display("FAIL pulse_high got=%b want=0010", obs_dp1); end
    checks++; if (obs_dp2 !== 4'b0) begin failures++; $display("FAIL pulse_width got=%b want=0000", obs_dp2); end
  endtask

  task automatic test_shield();
    clear_inputs();
    shield[2] = 1'b1; hit[2] = 1'b1; dmg[2] = 2'd3;
    for (int t = 0; t < 10; t++) begin
      do_tick();
      checks++; if (health[2] !== 3'd5 || invuln[2] !== 1'b0 || health !== exp_health()) begin
        failures++; $display("FAIL shield t=%0d health=%h want=%h invuln2=%b want=0", t, health, exp_health(), invuln[2]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_respawn_hit();
    clear_inputs();
    respawn[1] = 1'b1; hit[1] = 1'b1; dmg[1] = 2'd3;
    do_tick();
    clear_inputs();
    checks++; if (health[1] !== 3'd5 || health !== exp_health()) begin failures++; $display("FAIL respawn_health got=%h want=%h", health, exp_health()); end
    checks++; if (dead[1] !== 1'b0 || invuln[1] !== 1'b0) begin failures++; $display("FAIL respawn_state dead1=%b invuln1=%b want=0,0", dead[1], invuln[1]); end
  endtask

  task automatic test_all_dead_reset();
    int n;
    n = 0;
    while (exp_dead() != '1 && n < 2000) begin
      clear_inputs();
      hit = '1; dmg = '1;
      do_tick();
      n++;
    end
    clear_inputs();
    checks++; if (n >= 2000) begin failures++; $display("FAIL kill_all_timeout ticks=%0d want<2000", n); end
    checks++; if (all_dead !== 1'b1 || dead !== 4'b1111) begin failures++; $display("FAIL all_dead got=%b dead=%b want=1,1111", all_dead, dead); end
    checks++; if (health !== hvec_t'(0)) begin failures++; $display("FAIL all_dead_health got=%h want=0", health); end
    respawn[0] = 1'b1; do_tick(); clear_inputs();
    hit[0] = 1'b1; dmg[0] = 2'd1; do_tick(); clear_inputs();
    checks++; if (invuln[0] !== 1'b1 || health[0] !== 3'd4 || all_dead !== 1'b0) begin failures++; $display("FAIL pre_reset invuln0=%b health0=%0d all_dead=%b want=1,4,0", invuln[0], health[0], all_dead); end
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1 model_reset();
    checks++; if (health !== exp_health() || invuln !== 4'b0 || dead !== 4'b0 || all_dead !== 1'b0) begin
      failures++; $display("FAIL mid_reset health=%h want=%h invuln=%b dead=%b all_dead=%b", health, exp_health(), invuln, dead, all_dead);
    end
    @(negedge Clk) Reset = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      hit     = 4'($urandom);
      shield  = 4'($urandom) & 4'($urandom);
      dmg     = 8'($urandom);
      respawn = 4'($urandom) & 4'($urandom);
      do_tick();
      checks++; if (health !== exp_health() || dead !== exp_dead() || invuln !== exp_inv() || all_dead !== (&exp_dead())) begin
        failures++; $display("FAIL random t=%0d health=%h/%h dead=%b/%b invuln=%b/%b all_dead=%b", t, health, exp_health(), dead, exp_dead(), invuln, exp_inv(), all_dead);
      end
      checks++; if (obs_dp1 !== m_pulse || obs_dp2 !== 4'b0) begin
        failures++; $display("FAIL random_pulse t=%0d got=%b,%b want=%b,0000", t, obs_dp1, obs_dp2, m_pulse);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_invuln_window();
    test_saturate_death();
    test_shield();
    test_respawn_hit();
    test_all_dead_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout reached at time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
